// File: rtl/shift_exec_stage.sv
// Registered SLL/SRL/SRA stage with a valid/ready handshake on both sides.
// Define SHIFT_EXEC_SKID_EN to add a one-entry skid buffer so in_ready comes from a flop.
module shift_exec_stage #(
    parameter int N = 32,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shamt,
    input  logic [1:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_illegal
);

    logic [N-1:0] w_res;
    logic         w_ill;
    logic         w_in_fire;
    logic         w_out_fire;

    logic         r_out_valid;
    logic [N-1:0] r_out_data;
    logic         r_out_illegal;

    // op 10 passes the operand through untouched and flags it
    always_comb begin
        w_res = in_data;
        w_ill = 1'b0;
        case (in_op)
            2'b00:   w_res = in_data << in_shamt;
            2'b01:   w_res = in_data >> in_shamt;
            2'b11:   w_res = $unsigned($signed(in_data) >>> in_shamt);
            default: w_ill = 1'b1;
        endcase
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_illegal = r_out_illegal;

`ifdef SHIFT_EXEC_SKID_EN
    logic         r_skid_valid;
    logic [N-1:0] r_skid_data;
    logic         r_skid_illegal;
    logic         r_in_ready;

    // r_in_ready always mirrors !r_skid_valid; rst_n only masks it during reset
    assign in_ready = rst_n & r_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_data    <= '0;
            r_skid_illegal <= 1'b0;
            r_in_ready     <= 1'b1;
        end else if (!r_out_valid || w_out_fire) begin
            if (r_skid_valid) begin
                r_out_data    <= r_skid_data;
                r_out_illegal <= r_skid_illegal;
                r_skid_valid  <= 1'b0;
                r_in_ready    <= 1'b1;
            end else if (w_in_fire) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= w_res;
                r_out_illegal <= w_ill;
            end else begin
                r_out_valid   <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_valid   <= 1'b1;
            r_skid_data    <= w_res;
            r_skid_illegal <= w_ill;
            r_in_ready     <= 1'b0;
        end
    end
`else
    assign in_ready = rst_n & (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_res;
            r_out_illegal <= w_ill;
        end else if (w_out_fire) begin
            r_out_valid   <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 Parameter: N, default 32, datapath width in bits; the shift amount is $clog2(N) bits wide.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream offers an operation this cycle.
REQ-005 Port: in_ready  output  1  stage accepts the offered operation this cycle.
REQ-006 Port: in_data  input  N  operand to shift.
REQ-007 Port: in_shamt  input  $clog2(N)  shift amount, unsigned.
REQ-008 Port: in_op  input  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 illegal.
REQ-009 Port: out_valid  output  1  result register holds an undelivered result.
REQ-010 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-011 Port: out_data  output  N  shifted result.
REQ-012 Port: out_illegal  output  1  the delivered result came from in_op = 10.

Function
REQ-013 A transfer in or out SHALL occur only on a rising edge where the corresponding valid and ready are both 1.
REQ-014 SLL SHALL produce in_data shifted left by in_shamt, with zero fill.
REQ-015 SRL SHALL produce in_data shifted right by in_shamt, with zero fill.
REQ-016 SRA SHALL produce in_data shifted right by in_shamt, filled with in_data[N-1].
REQ-017 For in_op = 10, out_data SHALL equal in_data unshifted and out_illegal SHALL be 1; otherwise out_illegal SHALL be 0.
REQ-018 Results SHALL be computed from the input operands, registered, and presented on out_data exactly 1 cycle after acceptance when the stage is empty.
REQ-019 A shamt of 0 SHALL return in_data unchanged for every op; a shamt of N-1 SHALL leave one significant bit for SLL/SRL and a full sign fill for SRA.
REQ-020 States SHALL be EMPTY (out_valid=0) and FULL (out_valid=1); FULL with skid occupied is added by REQ-029.
REQ-021 Transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer with no input transfer; FULL->FULL on simultaneous output and input transfer, loading the new result.
REQ-022 out_data and out_illegal SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated.
REQ-024 in_data, in_shamt and in_op SHALL be ignored when in_valid=0, and out_ready SHALL be ignored when out_valid=0.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately clear out_valid, out_data and out_illegal to 0 and empty any skid entry, without waiting for clk.
REQ-026 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-027 Reset asserted mid-operation SHALL discard all held results; no result accepted before reset SHALL appear after it.

Configuration
REQ-028 Macro SHIFT_EXEC_SKID_EN SHALL select the input-ready structure.
REQ-029 With SHIFT_EXEC_SKID_EN defined:
- A one-entry skid register SHALL be present and in_ready SHALL be driven from a flop.
- in_ready SHALL equal !skid_valid, so it does not combinationally depend on out_ready.
- An input accepted while FULL and out_ready=0 SHALL go to the skid entry.
- The skid entry SHALL move to the output register on the next output transfer.
REQ-030 Without SHIFT_EXEC_SKID_EN, there SHALL be no skid register and in_ready SHALL equal (!out_valid || out_ready), combinationally.

Verification
REQ-031 Shift and extend: SRA, in_data=0x8000_00F0, shamt=4, out_ready=1 -> out_data=0xF800_000F one cycle later; SRL, same operand -> 0x0800_000F.
REQ-032 Shift-amount boundaries: SLL, in_data=0x0000_0001, shamt=31 -> 0x8000_0000; shamt=0 for all three ops -> out_data equals in_data.
REQ-033 Illegal op: in_op=10, in_data=0x1234_5678 -> out_data=0x1234_5678 with out_illegal=1; the next legal op delivers out_illegal=0.
REQ-034 Backpressure: three back-to-back ops with out_ready held 0 for 3 cycles:
- With the macro, in_ready falls after 2 accepts.
- Without the macro, in_ready falls after 1 accept.
- Both builds deliver the results in order with stable data.
REQ-035 Throughput: continuous in_valid=1 and out_ready=1 for 8 cycles -> 8 results, one per cycle, in order.
REQ-036 Async reset: rst_n pulled low between clock edges while FULL -> out_valid=0 before the next clk edge; nothing is emitted after release.
